bip_ctrl_unit: RTL

Parametrised, sequential control unit for the accumulator CPU; successor to the purely combinational instruction decoder.
- Owns the PC and fetches instructions with a valid handshake.
- Decodes the opcode into datapath strobes and stalls on data-RAM reads until acknowledged.
- Adds JMP and an illegal-opcode flag, and halts in a terminal state.
- Sits between instruction memory, data RAM and the accumulator/ALU datapath.

---
 rtl/bip_ctrl_unit.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/bip_ctrl_unit.sv
// Sequential control unit for the accumulator CPU: fetch handshake, decode, RAM-read stalls, JMP and HALT.
// Optional logic-op opcodes (AND/OR/XOR and immediate forms) are enabled by defining BIP_LOGIC_OPS_EN.
module bip_ctrl_unit #(
  parameter int OPCODE_WIDTH  = 5,
  parameter int OPERAND_WIDTH = 11,
  parameter int PC_WIDTH      = 11
) (
  input  logic                                  i_clk,
  input  logic                                  i_rst_n,
  input  logic [OPCODE_WIDTH+OPERAND_WIDTH-1:0] i_instr,
  input  logic                                  i_valid,
  input  logic                                  i_mem_ready,
  output logic [PC_WIDTH-1:0]                   o_pc,
  output logic [OPERAND_WIDTH-1:0]              o_operand,
  output logic [1:0]                            o_selA,
  output logic                                  o_selB,
  output logic [2:0]                            o_OP,
  output logic                                  o_WrAcc,
  output logic                                  o_WrPC,
  output logic                                  o_WrRam,
  output logic                                  o_RdRam,
  output logic                                  o_illegal,
  output logic                                  o_halted
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_EXEC,
    S_WAIT,
    S_HALT
  } state_t;

  state_t state, state_next;

  logic [PC_WIDTH-1:0]      pc;
  logic [OPCODE_WIDTH-1:0]  opcode;
  logic [OPERAND_WIDTH-1:0] operand;

  logic       upper_zero;
  logic       dec_ram_read;
  logic       dec_halt;
  logic       dec_jmp;
  logic       dec_illegal;
  logic       dec_wr_acc;
  logic       dec_wr_ram;
  logic [1:0] dec_sel_a;
  logic       dec_sel_b;
  logic [2:0] dec_op;

  // Opcode bits above the 5-bit map must be zero; the shift keeps this legal when OPCODE_WIDTH is exactly 5.
  assign upper_zero = ((opcode >> 5) == '0);

  always_comb begin
    dec_ram_read = 1'b0;
    dec_halt     = 1'b0;
    dec_jmp      = 1'b0;
    dec_illegal  = 1'b0;
    dec_wr_acc   = 1'b0;
    dec_wr_ram   = 1'b0;
    dec_sel_a    = 2'b00;
    dec_sel_b    = 1'b0;
    dec_op       = 3'b000;
    if (!upper_zero) begin
      dec_illegal = 1'b1;
    end else begin
      case (opcode[4:0])
        5'b00000: dec_halt = 1'b1;
        5'b00001: dec_wr_ram = 1'b1;
        5'b00010: dec_ram_read = 1'b1;
        5'b00011: begin dec_sel_a = 2'b01; dec_wr_acc = 1'b1; end
        5'b00100: begin dec_ram_read = 1'b1; dec_sel_a = 2'b10; end
        5'b00101: begin dec_sel_b = 1'b1; dec_sel_a = 2'b10; dec_wr_acc = 1'b1; end
        5'b00110: begin dec_ram_read = 1'b1; dec_sel_a = 2'b10; dec_op = 3'b001; end
        5'b00111: begin dec_sel_b = 1'b1; dec_sel_a = 2'b10; dec_op = 3'b001; dec_wr_acc = 1'b1; end
        5'b01000: dec_jmp = 1'b1;
`ifdef BIP_LOGIC_OPS_EN
        5'b01001: begin dec_ram_read = 1'b1; dec_sel_a = 2'b10; dec_op = 3'b010; end
        5'b01010: begin dec_sel_b = 1'b1; dec_sel_a = 2'b10; dec_op = 3'b010; dec_wr_acc = 1'b1; end
        5'b01011: begin dec_ram_read = 1'b1; dec_sel_a = 2'b10; dec_op = 3'b011; end
        5'b01100: begin dec_sel_b = 1'b1; dec_sel_a = 2'b10; dec_op = 3'b011; dec_wr_acc = 1'b1; end
        5'b01101: begin dec_ram_read = 1'b1; dec_sel_a = 2'b10; dec_op = 3'b100; end
        5'b01110: begin dec_sel_b = 1'b1; dec_sel_a = 2'b10; dec_op = 3'b100; dec_wr_acc = 1'b1; end
`endif
        default: dec_illegal = 1'b1;
      endcase
    end
  end

  always_comb begin
    state_next = state;
    o_selA     = 2'b00;
    o_selB     = 1'b0;
    o_OP       = 3'b000;
    o_WrAcc    = 1'b0;
    o_WrPC     = 1'b0;
    o_WrRam    = 1'b0;
    o_RdRam    = 1'b0;
    o_illegal  = 1'b0;
    o_halted   = 1'b0;
    case (state)
      S_IDLE:  state_next = S_FETCH;
      S_FETCH: if (i_valid) state_next = S_EXEC;
      S_EXEC: begin
        o_selA = dec_sel_a;
        o_selB = dec_sel_b;
        o_OP   = dec_op;
        if (dec_ram_read) begin
          o_RdRam    = 1'b1;
          state_next = S_WAIT;
        end else if (dec_halt) begin
          state_next = S_HALT;
        end else begin
          o_WrAcc    = dec_wr_acc;
          o_WrRam    = dec_wr_ram;
          o_WrPC     = 1'b1;
          o_illegal  = dec_illegal;
          state_next = S_FETCH;
        end
      end
      // Accumulator write and PC advance complete in the cycle the RAM acknowledges.
      S_WAIT: begin
        o_selA  = dec_sel_a;
        o_selB  = dec_sel_b;
        o_OP    = dec_op;
        o_RdRam = 1'b1;
        o_WrAcc = i_mem_ready;
        o_WrPC  = i_mem_ready;
        if (i_mem_ready) state_next = S_FETCH;
      end
      S_HALT:  o_halted = 1'b1;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= S_IDLE;
      pc      <= '0;
      opcode  <= '0;
      operand <= '0;
    end else begin
      state <= state_next;
      if (state == S_FETCH && i_valid) begin
        opcode  <= i_instr[OPCODE_WIDTH+OPERAND_WIDTH-1:OPERAND_WIDTH];
        operand <= i_instr[OPERAND_WIDTH-1:0];
      end
      if (o_WrPC) begin
        pc <= dec_jmp ? PC_WIDTH'(operand) : pc + PC_WIDTH'(1);
      end
    end
  end

  assign o_pc      = pc;
  assign o_operand = operand;

endmodule
